// File: rtl/famicom_multi_scanner.sv
// Multi-port Famicom/NES/SNES serial controller scanner: one shared latch and
// pulse line, per-channel synchronized data, periodic and on-demand scans.
module famicom_multi_scanner #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned BITS            = 8,
    parameter int unsigned LATCH_CYCLES    = 600,
    parameter int unsigned HALF_CYCLES     = 300,
    parameter int unsigned POLL_CYCLES     = 833333,
    parameter int unsigned ACTIVE_LOW_DATA = 1
) (
    input  logic                       fpga_clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       poll_now,
    input  logic [CHANNELS-1:0]        famicom_data,
    output logic                       famicom_latch,
    output logic                       famicom_pulse,
    output logic [CHANNELS*BITS-1:0]   buttons,
    output logic                       buttons_valid,
    output logic                       buttons_changed,
    output logic                       busy
);

    localparam int unsigned CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned POLL_W  = $clog2(POLL_CYCLES);
    localparam int unsigned IDX_W   = $clog2(BITS);
    localparam int unsigned LATCH_LAST = LATCH_CYCLES - 1;
    localparam int unsigned HALF_LAST  = HALF_CYCLES - 1;
    localparam int unsigned POLL_LAST  = POLL_CYCLES - 1;
    localparam int unsigned IDX_LAST   = BITS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_PULSE_HI,
        S_PULSE_LO,
        S_COMMIT
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [POLL_W-1:0]               timer_q, timer_d;
    logic [CHANNELS-1:0]             sync1_q, sync2_q;
    logic [CHANNELS-1:0][BITS-1:0]   shift_q, shift_d;
    logic                            latch_q, pulse_q, busy_q, valid_q, changed_q;
    logic [CHANNELS*BITS-1:0]        buttons_q;
    logic                            timer_wrap_c;
    logic                            sample_c;
    logic [CHANNELS*BITS-1:0]        commit_val_c;

    assign timer_wrap_c = (timer_q == POLL_W'(POLL_LAST));
    assign timer_d      = timer_wrap_c ? '0 : timer_q + POLL_W'(1);
    assign commit_val_c = (ACTIVE_LOW_DATA != 0) ? ~shift_q : shift_q;

    // Next-state logic; one shared phase counter times latch and both pulse halves
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        sample_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (poll_now || (timer_wrap_c && enable)) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt_q == CNT_W'(LATCH_LAST)) begin
                    sample_c = 1'b1;
                    cnt_d    = '0;
                    idx_d    = idx_q + IDX_W'(1);
                    state_d  = S_PULSE_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE_HI: begin
                if (cnt_q == CNT_W'(HALF_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_PULSE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PULSE_LO: begin
                if (cnt_q == CNT_W'(HALF_LAST)) begin
                    sample_c = 1'b1;
                    cnt_d    = '0;
                    if (idx_q == IDX_W'(IDX_LAST)) begin
                        state_d = S_COMMIT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_PULSE_HI;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (sample_c) begin
            for (int c = 0; c < CHANNELS; c++) begin
                shift_d[c][idx_q] = sync2_q[c];
            end
        end
    end

    // State, datapath and output registers; strobes decode from next state so pins come straight from flops
    always_ff @(posedge fpga_clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            sync1_q   <= famicom_data;
            sync2_q   <= sync1_q;
            shift_q   <= shift_d;
            latch_q   <= (state_d == S_LATCH);
            pulse_q   <= (state_d == S_PULSE_HI);
            busy_q    <= (state_d != S_IDLE);
            valid_q   <= (state_q == S_COMMIT);
            if (state_q == S_COMMIT) begin
                buttons_q <= commit_val_c;
                changed_q <= (commit_val_c != buttons_q);
            end else begin
                changed_q <= 1'b0;
            end
        end
    end

    assign famicom_latch   = latch_q;
    assign famicom_pulse   = pulse_q;
    assign busy            = busy_q;
    assign buttons_valid   = valid_q;
    assign buttons_changed = changed_q;
    assign buttons         = buttons_q;

endmodule

// File: tb/tb_famicom_multi_scanner.sv
// Self-checking bench for famicom_multi_scanner: controller shift-register model,
// directed vector table, randomized scans, auto-poll, drop and reset corners.
module tb_famicom_multi_scanner;

    localparam int unsigned CH    = 2;
    localparam int unsigned NB    = 8;
    localparam int unsigned LATCH = 4;
    localparam int unsigned HALF  = 2;
    localparam int unsigned POLL  = 64;
    localparam int unsigned SCAN_LEN = LATCH + (NB - 1) * 2 * HALF + 1;

    logic            fpga_clock;
    logic            reset_n;
    logic            enable;
    logic            poll_now;
    logic [CH-1:0]   famicom_data;
    logic            famicom_latch;
    logic            famicom_pulse;
    logic [CH*NB-1:0] buttons;
    logic            buttons_valid;
    logic            buttons_changed;
    logic            busy;

    famicom_multi_scanner #(
        .CHANNELS(CH), .BITS(NB), .LATCH_CYCLES(LATCH), .HALF_CYCLES(HALF),
        .POLL_CYCLES(POLL), .ACTIVE_LOW_DATA(1)
    ) dut (
        .fpga_clock(fpga_clock), .reset_n(reset_n), .enable(enable), .poll_now(poll_now),
        .famicom_data(famicom_data), .famicom_latch(famicom_latch), .famicom_pulse(famicom_pulse),
        .buttons(buttons), .buttons_valid(buttons_valid), .buttons_changed(buttons_changed),
        .busy(busy)
    );

    initial begin
        fpga_clock = 1'b0;
        forever #5 fpga_clock = ~fpga_clock;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Controller model: 4021-style shift register, pressed buttons drive the line low
    logic [NB-1:0] pat [CH];
    int  ctl_idx = 0;
    logic ctl_prev_pulse = 1'b0;

    always @(negedge fpga_clock) begin
        if (famicom_latch) ctl_idx = 0;
        else if (famicom_pulse && !ctl_prev_pulse) ctl_idx = ctl_idx + 1;
        ctl_prev_pulse = famicom_pulse;
    end

    always_comb begin
        famicom_data = '0;
        for (int c = 0; c < CH; c++) begin
            famicom_data[c] = (ctl_idx < NB) ? ~pat[c][ctl_idx[2:0]] : 1'b0;
        end
    end

    logic [15:0] model_prev = 16'h0;

    // One on-demand scan with waveform checks; expected result supplied by caller
    task automatic run_scan(input string tag, input logic [15:0] exp_btn, input logic exp_chg);
        int cyc, latch_n, first_latch, rises, p_hi, ovl, lat;
        logic got, prevp;
        logic [15:0] btn;
        logic chg;
        cyc = 0; latch_n = 0; first_latch = 0; rises = 0; p_hi = 0; ovl = 0; lat = 0;
        got = 1'b0; prevp = 1'b0; btn = '0; chg = 1'b0;
        @(negedge fpga_clock);
        poll_now = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge fpga_clock);
            poll_now = 1'b0;
            cyc++;
            if (famicom_latch) begin
                latch_n++;
                if (first_latch == 0) first_latch = cyc;
            end
            if (famicom_pulse && !prevp) rises++;
            if (famicom_pulse) p_hi++;
            if (famicom_latch && famicom_pulse) ovl++;
            prevp = famicom_pulse;
            if (buttons_valid) begin
                got = 1'b1;
                lat = cyc - 1;
                btn = buttons;
                chg = buttons_changed;
            end
        end
        check({tag, " valid_seen"}, 32'(got), 32'd1);
        check({tag, " buttons"}, 32'(btn), 32'(exp_btn));
        check({tag, " changed"}, 32'(chg), 32'(exp_chg));
        check({tag, " latch_cycles"}, 32'(latch_n), 32'(LATCH));
        check({tag, " latch_first"}, 32'(first_latch), 32'd1);
        check({tag, " pulse_rises"}, 32'(rises), 32'(NB - 1));
        check({tag, " pulse_high_cycles"}, 32'(p_hi), 32'((NB - 1) * HALF));
        check({tag, " latch_pulse_overlap"}, 32'(ovl), 32'd0);
        check({tag, " valid_latency"}, 32'(lat), 32'(SCAN_LEN));
        @(negedge fpga_clock);
        check({tag, " valid_one_cycle"}, 32'(buttons_valid), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
        check({tag, " buttons_hold"}, 32'(buttons), 32'(exp_btn));
    endtask

    typedef struct {
        logic [7:0]  p0;
        logic [7:0]  p1;
        logic [15:0] exp_btn;
        logic        exp_chg;
    } vec_t;

    vec_t tbl [3];

    initial begin
        int bad, rise_n, found, vcnt;
        int rises [$];
        logic prevl;

        tbl[0] = '{p0: 8'hA5, p1: 8'h01, exp_btn: 16'h01A5, exp_chg: 1'b1};
        tbl[1] = '{p0: 8'hA5, p1: 8'h01, exp_btn: 16'h01A5, exp_chg: 1'b0};
        tbl[2] = '{p0: 8'hA5, p1: 8'h81, exp_btn: 16'h81A5, exp_chg: 1'b1};

        pat[0] = 8'h00; pat[1] = 8'h00;
        reset_n = 1'b0; enable = 1'b0; poll_now = 1'b0;

        // Reset and long idle
        repeat (5) @(negedge fpga_clock);
        check("reset_outputs", 32'({famicom_latch, famicom_pulse, busy, buttons_valid, buttons_changed, buttons}), 32'd0);
        reset_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge fpga_clock);
            if (famicom_latch || famicom_pulse || busy || buttons_valid || buttons_changed || buttons != 0) bad++;
        end
        check("idle_quiet_cycles", 32'(bad), 32'd0);

        // Directed vector table
        for (int i = 0; i < 3; i++) begin
            pat[0] = tbl[i].p0;
            pat[1] = tbl[i].p1;
            run_scan($sformatf("vec%0d", i), tbl[i].exp_btn, tbl[i].exp_chg);
        end
        model_prev = 16'h81A5;

        // Randomized scans against the button-pattern model
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp;
            if ($urandom_range(0, 3) != 0) begin
                pat[0] = 8'($urandom);
                pat[1] = 8'($urandom);
            end
            exp = {pat[1], pat[0]};
            run_scan($sformatf("rand%0d", i), exp, exp != model_prev);
            model_prev = exp;
        end

        // Auto-poll period with a dropped mid-scan poll_now
        @(negedge fpga_clock);
        enable = 1'b1;
        prevl = 1'b0; rise_n = 0; vcnt = 0; bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge fpga_clock);
            poll_now = 1'b0;
            if (famicom_latch && !prevl) begin
                rises.push_back(cyc);
                rise_n++;
            end
            prevl = famicom_latch;
            if (rise_n == 2 && cyc == rises[1] + 10) poll_now = 1'b1;
            if (buttons_valid) begin
                vcnt++;
                if (buttons_changed || buttons != model_prev) bad++;
            end
        end
        check("auto_scan_count", 32'(rise_n >= 5), 32'd1);
        for (int i = 1; i < rises.size(); i++) begin
            check($sformatf("auto_period%0d", i), 32'(rises[i] - rises[i-1]), 32'(POLL));
        end
        check("auto_commit_stable", 32'(bad), 32'd0);
        check("auto_commit_count", 32'(vcnt >= 4), 32'd1);

        // Dropping enable mid-scan still finishes that scan, then no further scans
        found = 0;
        for (int cyc = 0; cyc < 100 && found == 0; cyc++) begin
            @(negedge fpga_clock);
            if (famicom_latch) found = 1;
        end
        check("auto_scan_found", 32'(found), 32'd1);
        enable = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
            @(negedge fpga_clock);
            if (buttons_valid) found = 1;
        end
        check("enable_drop_completes", 32'(found), 32'd1);
        bad = 0;
        repeat (200) begin
            @(negedge fpga_clock);
            if (famicom_latch || busy) bad++;
        end
        check("disabled_no_scan", 32'(bad), 32'd0);

        // Reset during PULSE_LO of bit 3
        pat[0] = 8'h3C; pat[1] = 8'hC3;
        @(negedge fpga_clock);
        poll_now = 1'b1;
        repeat (15) begin
            @(negedge fpga_clock);
            poll_now = 1'b0;
        end
        check("midscan_in_pulse_lo", 32'({famicom_latch, famicom_pulse, busy}), 32'b001);
        reset_n = 1'b0;
        @(negedge fpga_clock);
        check("midscan_reset_outputs", 32'({famicom_latch, famicom_pulse, busy, buttons_valid, buttons_changed, buttons}), 32'd0);
        repeat (3) @(negedge fpga_clock);
        reset_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge fpga_clock);
            if (buttons_valid || busy || buttons != 0) bad++;
        end
        check("midscan_no_commit", 32'(bad), 32'd0);
        model_prev = 16'h0;
        run_scan("post_reset", {pat[1], pat[0]}, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/famicom_multi_scanner.md
Name: famicom_multi_scanner

Overview:
- Parametrised successor to the single-port Famicom/NES serial game-controller interface used by the application shell.
- Scans CHANNELS controllers in parallel, using one shared latch and one shared pulse line, with a per-channel data input.
- Supports BITS-long shift sequences: 8 for NES/Famicom, 16 for SNES.
- Provides a periodic auto-poll timer and an on-demand scan, and commits all channels atomically with valid/changed strobes. It feeds the loader/program-select logic and any application that needs controller state.

Parameters:
- CHANNELS, 2, number of controller ports; each has its own data input, all share latch/pulse.
- BITS, 8, button bits shifted per controller per scan (legal range 2..32).
- LATCH_CYCLES, 600, latch high time in fpga_clock cycles (12 us at 50 MHz); minimum 2.
- HALF_CYCLES, 300, pulse high time and pulse low time, each in cycles (6 us); minimum 1.
- POLL_CYCLES, 833333, auto-poll period in cycles (60 Hz at 50 MHz); minimum 2.
- ACTIVE_LOW_DATA, 1, when 1 the data line is inverted so that pressed reads as 1.

Ports:
- fpga_clock  input  1  single clock; all logic is synchronous to its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  gates auto-poll scan starts.
- poll_now  input  1  single-cycle request for an immediate scan.
- famicom_data  input  CHANNELS  serial data from each controller (asynchronous).
- famicom_latch  output  1  shared latch strobe.
- famicom_pulse  output  1  shared clock/pulse strobe.
- buttons  output  CHANNELS*BITS  committed state; channel c bit k is at [c*BITS+k]; bit 0 is the first bit shifted (A).
- buttons_valid  output  1  one-cycle strobe on each commit.
- buttons_changed  output  1  one-cycle strobe, coincident with buttons_valid, when the committed value differs from the previous one.
- busy  output  1  high while a scan is in progress.

Behaviour:
- Reset (reset_n=0 on a clock edge): the state goes to IDLE. All outputs go to 0 (latch, pulse, buttons, valid, changed, busy). The poll timer, shift registers and synchronizers clear. This applies mid-scan too: the scan is aborted and nothing is committed.
- Input synchronization: each famicom_data bit passes through a 2-flop synchronizer. Sampling uses the synchronized value. Bench timings account for this 2-cycle input delay.
- Poll timer: free-running counter, 0..POLL_CYCLES-1, wraps to 0. A wrap with enable=1 raises a start request.
- Start: in IDLE, if poll_now=1 or an auto start request is present, the block moves to LATCH on the next edge.
- Requests arriving while busy=1 are dropped, not queued. This covers both poll_now and timer wraps.
- Deasserting enable mid-scan does not abort the scan.
- States:
  - IDLE: latch=0, pulse=0, busy=0.
  - LATCH: latch=1, busy=1, held for LATCH_CYCLES cycles. On the last LATCH cycle, bit 0 of every channel is sampled.
  - PULSE_HI: latch=0, pulse=1, held for HALF_CYCLES cycles.
  - PULSE_LO: pulse=0, held for HALF_CYCLES cycles. On the last cycle, bit k is sampled. If k=BITS-1, go to COMMIT; otherwise k increments and the state returns to PULSE_HI.
  - COMMIT: one cycle, busy=1. On the next edge, buttons takes the shifted value (inverted if ACTIVE_LOW_DATA), buttons_valid=1, and buttons_changed = (new != old). State returns to IDLE.
- Scan length: from the cycle after the start edge to the COMMIT cycle inclusive, the scan takes LATCH_CYCLES + (BITS-1)*2*HALF_CYCLES + 1 cycles. There are exactly BITS-1 pulse rising edges per scan.
- latch and pulse are never high in the same cycle. Both outputs come directly from flops (no glitches).
- Internal counters are sized with $clog2 of their parameter. The bit index wraps only through the COMMIT exit, never arithmetically.
- buttons is stable between commits. The first commit after reset compares against 0.

Test Plan:
- Reset and idle: hold reset_n=0 for 5 cycles, then release with enable=0 and poll_now=0 for 1000 cycles. All outputs stay 0 and latch/pulse never toggle.
- Single scan timing (CHANNELS=2, BITS=8, LATCH=4, HALF=2, ACTIVE_LOW_DATA=1): pulse poll_now. latch is high for exactly 4 cycles, followed by 7 pulses each 2 high/2 low, then COMMIT. buttons_valid appears 33 cycles after the start edge.
- Data mapping: the controller model drives ch0 pressed pattern 8'b1010_0101 and ch1 8'b0000_0001 (LSB first, data low = pressed). Result: buttons=16'h01A5, and buttons_changed=1 on the first commit.
- Changed detect: repeat the identical scan and get valid=1, changed=0. Then flip ch1 bit 7 and get buttons=16'h81A5 with changed=1.
- Auto-poll and drop (POLL_CYCLES=64): with enable=1, scans start every 64 cycles. A poll_now issued mid-scan produces no extra scan. With enable=0, the timer wraps but no scan starts.
- Reset mid-scan: assert reset_n=0 during the PULSE_LO of bit 3. All outputs go to 0 on the next edge, there is no commit, and buttons stays 0. A fresh poll_now after release completes normally.
